// File: rtl/hack_cpu_if.sv
// Bus bundle between the Hack CPU core and its instruction ROM / data RAM.
// The master side is the CPU; the slave side is the memory system (or a testbench).
interface hack_cpu_if;
   logic [15:0] instruction;
   logic [15:0] inM;
   logic [15:0] outM;
   logic        writeM;
   logic [14:0] addressM;
   logic [14:0] pc;

   modport master (
      input  instruction,
      input  inM,
      output outM,
      output writeM,
      output addressM,
      output pc
   );

   modport slave (
      output instruction,
      output inM,
      input  outM,
      input  writeM,
      input  addressM,
      input  pc
   );
endinterface

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU core: A/D/PC registers, C-instruction decode, jump logic.
// ALU16 is the standard Hack ALU; it is computed every cycle, even for A-instructions.
module ALU16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng
);
   logic [15:0] x_z, x_n, y_z, y_n, f_out;

   always_comb begin
      x_z   = zx ? 16'h0000 : x;
      x_n   = nx ? ~x_z : x_z;
      y_z   = zy ? 16'h0000 : y;
      y_n   = ny ? ~y_z : y_z;
      f_out = f ? (x_n + y_n) : (x_n & y_n);
      out   = no ? ~f_out : f_out;
      zr    = (out == 16'h0000);
      ng    = out[15];
   end
endmodule

module hack_cpu (
   input  logic            clk,
   input  logic            reset,
   hack_cpu_if.master      bus
);
   logic [15:0] a_q, a_d;
   logic [15:0] d_q, d_d;
   logic [14:0] pc_q, pc_d;

   logic        is_c;
   logic        sel_m;
   logic        d1, d2, d3;
   logic        j1, j2, j3;
   logic        jump;
   logic [15:0] alu_y;
   logic [15:0] alu_out;
   logic        alu_zr;
   logic        alu_ng;

   assign is_c  = bus.instruction[15];
   assign sel_m = bus.instruction[12];
   assign d1    = bus.instruction[5];
   assign d2    = bus.instruction[4];
   assign d3    = bus.instruction[3];
   assign j1    = bus.instruction[2];
   assign j2    = bus.instruction[1];
   assign j3    = bus.instruction[0];

   assign alu_y = sel_m ? bus.inM : a_q;

   ALU16 u_alu (
      .x   (d_q),
      .y   (alu_y),
      .zx  (bus.instruction[11]),
      .nx  (bus.instruction[10]),
      .zy  (bus.instruction[9]),
      .ny  (bus.instruction[8]),
      .f   (bus.instruction[7]),
      .no  (bus.instruction[6]),
      .out (alu_out),
      .zr  (alu_zr),
      .ng  (alu_ng)
   );

   assign jump = is_c & ((j1 & alu_ng) | (j2 & alu_zr) | (j3 & ~alu_ng & ~alu_zr));

   always_comb begin
      a_d  = a_q;
      d_d  = d_q;
      pc_d = pc_q + 15'd1;
      if (!is_c) begin
         a_d = {1'b0, bus.instruction[14:0]};
      end else begin
         if (d1) a_d = alu_out;
         if (d2) d_d = alu_out;
      end
      // Jump target is the A value held before this edge, even when d1 reloads A.
      if (jump) pc_d = a_q[14:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q  <= 16'h0000;
         d_q  <= 16'h0000;
         pc_q <= 15'h0000;
      end else begin
         a_q  <= a_d;
         d_q  <= d_d;
         pc_q <= pc_d;
      end
   end

   assign bus.outM     = alu_out;
   assign bus.writeM   = is_c & d3 & ~reset;
   assign bus.addressM = a_q[14:0];
   assign bus.pc       = pc_q;
endmodule

// File: tb/tb_hack_cpu.sv
// Directed self-checking bench for hack_cpu: one task per feature, inline comparisons.
module tb_hack_cpu;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   hack_cpu_if bus ();

   hack_cpu dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present an instruction/inM pair and let combinational outputs settle.
   task automatic drive(input logic [15:0] instr, input logic [15:0] inm);
      bus.instruction = instr;
      bus.inM         = inm;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exec(input logic [15:0] instr, input logic [15:0] inm);
      drive(instr, inm);
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(16'hE308, 16'h0000);
      tick();
      tick();
      n_vec++;
      if (bus.pc !== 15'd0) begin
         n_err++;
         $display("FAIL reset_pc: got %h expected %h", bus.pc, 15'd0);
      end
      n_vec++;
      if (bus.addressM !== 15'd0) begin
         n_err++;
         $display("FAIL reset_addressM: got %h expected %h", bus.addressM, 15'd0);
      end
      n_vec++;
      if (bus.writeM !== 1'b0) begin
         n_err++;
         $display("FAIL reset_writeM: got %b expected 0", bus.writeM);
      end
      reset = 1'b0;
      exec(16'h0064, 16'h0000);
      n_vec++;
      if (bus.addressM !== 15'd100) begin
         n_err++;
         $display("FAIL ainst_addressM: got %0d expected 100", bus.addressM);
      end
      n_vec++;
      if (bus.pc !== 15'd1) begin
         n_err++;
         $display("FAIL ainst_pc: got %0d expected 1", bus.pc);
      end
      $display("test_reset done: pc=%0d addressM=%0d", bus.pc, bus.addressM);
   endtask

   task automatic test_d_arith();
      exec(16'h0064, 16'h0000);   // A=100
      exec(16'hEC10, 16'h0000);   // D=A
      exec(16'h0003, 16'h0000);   // A=3
      exec(16'hE090, 16'h0000);   // D=D+A -> 103
      drive(16'hE308, 16'h0000);  // M=D
      n_vec++;
      if (bus.outM !== 16'd103) begin
         n_err++;
         $display("FAIL darith_outM: got %0d expected 103", bus.outM);
      end
      n_vec++;
      if (bus.writeM !== 1'b1) begin
         n_err++;
         $display("FAIL darith_writeM: got %b expected 1", bus.writeM);
      end
      n_vec++;
      if (bus.addressM !== 15'd3) begin
         n_err++;
         $display("FAIL darith_addressM: got %0d expected 3", bus.addressM);
      end
      tick();
      $display("test_d_arith done: outM=%0d", bus.outM);
   endtask

   task automatic test_m_read();
      exec(16'h0007, 16'h0000);   // A=7
      drive(16'hFDD0, 16'd41);    // D=M+1
      n_vec++;
      if (bus.writeM !== 1'b0) begin
         n_err++;
         $display("FAIL mread_writeM: got %b expected 0", bus.writeM);
      end
      n_vec++;
      if (bus.addressM !== 15'd7) begin
         n_err++;
         $display("FAIL mread_addressM: got %0d expected 7", bus.addressM);
      end
      tick();
      drive(16'hE308, 16'h0000);  // M=D exposes D
      n_vec++;
      if (bus.outM !== 16'd42) begin
         n_err++;
         $display("FAIL mread_D: got %0d expected 42", bus.outM);
      end
      tick();
      $display("test_m_read done");
   endtask

   task automatic test_jumps();
      exec(16'h0005, 16'h0000);   // A=5
      exec(16'hEC10, 16'h0000);   // D=5
      exec(16'h0014, 16'h0000);   // A=20
      exec(16'hE301, 16'h0000);   // D;JGT taken
      n_vec++;
      if (bus.pc !== 15'd20) begin
         n_err++;
         $display("FAIL jgt_taken_pc: got %0d expected 20", bus.pc);
      end
      exec(16'hEA90, 16'h0000);   // D=0, pc 20->21
      exec(16'hE301, 16'h0000);   // D;JGT not taken, pc 21->22
      n_vec++;
      if (bus.pc !== 15'd22) begin
         n_err++;
         $display("FAIL jgt_nottaken_pc: got %0d expected 22", bus.pc);
      end
      exec(16'h0030, 16'h0000);   // A=48, pc 23
      exec(16'hEA87, 16'h0000);   // 0;JMP
      n_vec++;
      if (bus.pc !== 15'd48) begin
         n_err++;
         $display("FAIL jmp_pc: got %0d expected 48", bus.pc);
      end
      exec(16'hEE90, 16'h0000);   // D=-1, pc 49
      exec(16'hE304, 16'h0000);   // D;JLT taken
      n_vec++;
      if (bus.pc !== 15'd48) begin
         n_err++;
         $display("FAIL jlt_pc: got %0d expected 48", bus.pc);
      end
      $display("test_jumps done: pc=%0d", bus.pc);
   endtask

   task automatic test_am_jump();
      exec(16'h0009, 16'h0000);   // A=9
      drive(16'hFCAA, 16'd1);     // AM=M-1;JEQ
      n_vec++;
      if (bus.addressM !== 15'd9) begin
         n_err++;
         $display("FAIL amjeq_addressM: got %0d expected 9", bus.addressM);
      end
      n_vec++;
      if (bus.outM !== 16'd0) begin
         n_err++;
         $display("FAIL amjeq_outM: got %0d expected 0", bus.outM);
      end
      n_vec++;
      if (bus.writeM !== 1'b1) begin
         n_err++;
         $display("FAIL amjeq_writeM: got %b expected 1", bus.writeM);
      end
      tick();
      n_vec++;
      if (bus.addressM !== 15'd0) begin
         n_err++;
         $display("FAIL amjeq_newA: got %0d expected 0", bus.addressM);
      end
      n_vec++;
      if (bus.pc !== 15'd9) begin
         n_err++;
         $display("FAIL amjeq_pc: got %0d expected 9", bus.pc);
      end
      exec(16'h0009, 16'h0000);   // A=9
      drive(16'hFCA2, 16'd1);     // A=M-1;JEQ, no memory write
      n_vec++;
      if (bus.writeM !== 1'b0) begin
         n_err++;
         $display("FAIL ajeq_writeM: got %b expected 0", bus.writeM);
      end
      tick();
      n_vec++;
      if (bus.pc !== 15'd9 || bus.addressM !== 15'd0) begin
         n_err++;
         $display("FAIL ajeq_pc_addr: got pc=%0d addr=%0d expected pc=9 addr=0", bus.pc, bus.addressM);
      end
      $display("test_am_jump done");
   endtask

   task automatic test_wrap_and_reset();
      exec(16'h7FFF, 16'h0000);
      exec(16'hEA87, 16'h0000);
      n_vec++;
      if (bus.pc !== 15'h7FFF) begin
         n_err++;
         $display("FAIL wrap_jmp_pc: got %h expected 7fff", bus.pc);
      end
      exec(16'h0005, 16'h0000);
      n_vec++;
      if (bus.pc !== 15'h0000) begin
         n_err++;
         $display("FAIL wrap_pc: got %h expected 0000", bus.pc);
      end
      exec(16'h0011, 16'h0000);   // A=17
      exec(16'hEC10, 16'h0000);   // D=17
      reset = 1'b1;
      drive(16'hFCAA, 16'd5);
      n_vec++;
      if (bus.writeM !== 1'b0) begin
         n_err++;
         $display("FAIL rst_comb_writeM: got %b expected 0", bus.writeM);
      end
      exec(16'hEA87, 16'h0000);
      n_vec++;
      if (bus.pc !== 15'd0 || bus.addressM !== 15'd0 || bus.writeM !== 1'b0) begin
         n_err++;
         $display("FAIL midrst: got pc=%0d addr=%0d wr=%b expected 0 0 0", bus.pc, bus.addressM, bus.writeM);
      end
      reset = 1'b0;
      drive(16'hE308, 16'h0000);  // D must have been cleared
      n_vec++;
      if (bus.outM !== 16'd0) begin
         n_err++;
         $display("FAIL midrst_D: got %0d expected 0", bus.outM);
      end
      tick();
      $display("test_wrap_and_reset done: pc=%0d", bus.pc);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus.instruction = 16'h0000;
      bus.inM         = 16'h0000;
      test_reset();
      test_d_arith();
      test_m_read();
      test_jumps();
      test_am_jump();
      test_wrap_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
